bp_io_req_arbiter: RTL

BP_IO_REQ_ARBITER -- requirements
Module: bp_io_req_arbiter

---
 rtl/bp_io_req_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bp_io_req_arbiter.sv
// bp_io_req_arbiter: shares one IO command channel among num_req_p requesters.
// Round-robin grant, a global credit counter that limits outstanding commands,
// and tag-based routing of responses back to the requester that issued them.
// An out-of-range response tag, or a response that arrives with nothing
// outstanding, sets a sticky error flag.
module bp_io_req_arbiter #(
    parameter int num_req_p         = 2,
    parameter int msg_width_p       = 128,
    parameter int max_outstanding_p = 4,
    localparam int tag_w = (num_req_p > 1) ? $clog2(num_req_p) : 1,
    localparam int cnt_w = $clog2(max_outstanding_p + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [num_req_p*msg_width_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]           req_v_i,
    output logic [num_req_p-1:0]           req_yumi_o,
    output logic [msg_width_p-1:0]         io_cmd_o,
    output logic [tag_w-1:0]               io_cmd_tag_o,
    output logic                           io_cmd_v_o,
    input  logic                           io_cmd_ready_i,
    input  logic [msg_width_p-1:0]         io_resp_i,
    input  logic [tag_w-1:0]               io_resp_tag_i,
    input  logic                           io_resp_v_i,
    output logic                           io_resp_yumi_o,
    output logic [msg_width_p-1:0]         resp_o,
    output logic [num_req_p-1:0]           resp_v_o,
    input  logic [num_req_p-1:0]           resp_ready_i,
    input  logic                           drain_i,
    output logic [cnt_w-1:0]               outstanding_o,
    output logic                           idle_o,
    output logic                           err_o
);

    localparam logic [cnt_w-1:0] MaxCnt  = cnt_w'(max_outstanding_p);
    localparam logic [tag_w-1:0] LastTag = tag_w'(num_req_p - 1);

    logic [tag_w-1:0] r_rr;
    logic [cnt_w-1:0] r_count;
    logic             r_err;

    logic [tag_w-1:0] w_sel;
    logic             w_any;
    logic             w_can_issue;
    logic             w_grant;
    logic             w_tag_in_range;
    logic             w_resp_take;
    logic             w_resp_drop;

    // Round-robin search: first valid requester starting at r_rr, wrapping.
    always_comb begin
        int unsigned v_idx;
        v_idx = 0;
        w_sel = '0;
        w_any = 1'b0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            v_idx = (32'(r_rr) + k) % 32'(num_req_p);
            if (!w_any && req_v_i[tag_w'(v_idx)]) begin
                w_any = 1'b1;
                w_sel = tag_w'(v_idx);
            end
        end
    end

    // Command side: valid is independent of ready; yumi only on handshake.
    // Outputs are forced inactive while reset is held.
    always_comb begin
        w_can_issue  = reset_n_i & ~drain_i & (r_count < MaxCnt) & w_any;
        w_grant      = w_can_issue & io_cmd_ready_i;
        io_cmd_v_o   = w_can_issue;
        io_cmd_tag_o = w_sel;
        io_cmd_o     = '0;
        req_yumi_o   = '0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            if (tag_w'(k) == w_sel) begin
                io_cmd_o = req_data_i[k*msg_width_p +: msg_width_p];
            end
        end
        if (w_grant) begin
            req_yumi_o[w_sel] = 1'b1;
        end
    end

    // Response side: route by tag, or drop (consume without delivery) when
    // the tag names no requester.
    always_comb begin
        w_tag_in_range = (32'(io_resp_tag_i) < 32'(num_req_p));
        resp_o         = io_resp_i;
        resp_v_o       = '0;
        w_resp_take    = 1'b0;
        w_resp_drop    = reset_n_i & io_resp_v_i & ~w_tag_in_range;
        if (reset_n_i && io_resp_v_i && w_tag_in_range) begin
            resp_v_o[io_resp_tag_i] = 1'b1;
            w_resp_take             = resp_ready_i[io_resp_tag_i];
        end
        io_resp_yumi_o = w_resp_take | w_resp_drop;
    end

    // Pointer, credit count and sticky error state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rr    <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_rr <= (w_sel == LastTag) ? '0 : w_sel + 1'b1;
            end
            if (w_grant && !w_resp_take) begin
                r_count <= r_count + 1'b1;
            end else if (!w_grant && w_resp_take) begin
                if (r_count == '0) begin
                    r_err <= 1'b1;
                end else begin
                    r_count <= r_count - 1'b1;
                end
            end
            if (w_resp_drop) begin
                r_err <= 1'b1;
            end
        end
    end

    assign outstanding_o = r_count;
    assign idle_o        = (r_count == '0);
    assign err_o         = r_err;

endmodule
